// File: rtl/rob_param_if.sv
// rtl/rob_param_if.sv - reorder buffer alloc / writeback / lookup / commit bundle
interface rob_param_if #(
  parameter int DEPTH_LOG2 = 5,
  parameter int NUM_WB     = 3,
  parameter int REG_W      = 5
);
  logic                         alloc_valid;
  logic [2:0]                   alloc_type;
  logic [REG_W-1:0]             alloc_rd;
  logic [31:0]                  alloc_pc;
  logic [31:0]                  alloc_tgt;
  logic                         alloc_pred;
  logic                         alloc_done;
  logic [31:0]                  alloc_value;
  logic [1:0]                   alloc_st_size;
  logic                         alloc_ready;
  logic [DEPTH_LOG2-1:0]        alloc_id;
  logic [NUM_WB-1:0]            wb_valid;
  logic [NUM_WB*DEPTH_LOG2-1:0] wb_id;
  logic [NUM_WB*32-1:0]         wb_value;
  logic [NUM_WB*32-1:0]         wb_addr;
  logic [DEPTH_LOG2-1:0]        q1_id;
  logic [DEPTH_LOG2-1:0]        q2_id;
  logic                         q1_found;
  logic                         q2_found;
  logic [31:0]                  q1_value;
  logic [31:0]                  q2_value;
  logic                         rf_valid;
  logic [REG_W-1:0]             rf_rd;
  logic [31:0]                  rf_value;
  logic [DEPTH_LOG2-1:0]        rf_rob_id;
  logic                         st_valid;
  logic                         st_ready;
  logic [31:0]                  st_addr;
  logic [31:0]                  st_data;
  logic [1:0]                   st_size;
  logic                         pred_valid;
  logic [31:0]                  pred_pc;
  logic                         pred_taken;
  logic                         flush_out;
  logic [31:0]                  flush_pc;
  logic                         halt_out;
  logic                         empty_out;
  logic                         full_out;

  modport master (
    output alloc_valid, alloc_type, alloc_rd, alloc_pc, alloc_tgt, alloc_pred,
           alloc_done, alloc_value, alloc_st_size, wb_valid, wb_id, wb_value,
           wb_addr, q1_id, q2_id, st_ready,
    input  alloc_ready, alloc_id, q1_found, q2_found, q1_value, q2_value,
           rf_valid, rf_rd, rf_value, rf_rob_id, st_valid, st_addr, st_data,
           st_size, pred_valid, pred_pc, pred_taken, flush_out, flush_pc,
           halt_out, empty_out, full_out
  );

  modport slave (
    input  alloc_valid, alloc_type, alloc_rd, alloc_pc, alloc_tgt, alloc_pred,
           alloc_done, alloc_value, alloc_st_size, wb_valid, wb_id, wb_value,
           wb_addr, q1_id, q2_id, st_ready,
    output alloc_ready, alloc_id, q1_found, q2_found, q1_value, q2_value,
           rf_valid, rf_rd, rf_value, rf_rob_id, st_valid, st_addr, st_data,
           st_size, pred_valid, pred_pc, pred_taken, flush_out, flush_pc,
           halt_out, empty_out, full_out
  );
endinterface

// File: rtl/rob_param.sv
// rtl/rob_param.sv - parametrised in-order-commit reorder buffer
module rob_param #(
  parameter int DEPTH_LOG2 = 5,
  parameter int NUM_WB     = 3,
  parameter int REG_W      = 5
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  rob_param_if.slave rob
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] id_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;
  localparam cnt_t       FULL_CNT = cnt_t'(DEPTH);
  localparam logic [2:0] T_REG    = 3'd0;
  localparam logic [2:0] T_STORE  = 3'd1;
  localparam logic [2:0] T_BRANCH = 3'd2;
  localparam logic [2:0] T_JALR   = 3'd3;
  localparam logic [2:0] T_EXIT   = 3'd4;

  logic [2:0]       e_type  [DEPTH];
  logic [REG_W-1:0] e_rd    [DEPTH];
  logic [31:0]      e_pc    [DEPTH];
  logic [31:0]      e_tgt   [DEPTH];
  logic [31:0]      e_value [DEPTH];
  logic [31:0]      e_addr  [DEPTH];
  logic             e_pred  [DEPTH];
  logic [1:0]       e_size  [DEPTH];
  logic [DEPTH-1:0] e_done;
  id_t              head;
  id_t              tail;
  cnt_t             count;

  function automatic logic in_flight(input id_t id, input id_t h, input cnt_t n);
    id_t off;
    off = id - h;
    return {1'b0, off} < n;
  endfunction

  logic do_alloc;
  assign rob.full_out    = (count == FULL_CNT);
  assign rob.empty_out   = (count == '0);
  assign rob.alloc_ready = !rob.full_out && !rob.flush_out;
  assign rob.alloc_id    = tail;
  assign do_alloc        = rob.alloc_valid && rob.alloc_ready;

  id_t               wb_id_a   [NUM_WB];
  logic [31:0]       wb_val_a  [NUM_WB];
  logic [31:0]       wb_addr_a [NUM_WB];
  logic [NUM_WB-1:0] wb_ok;

  always_comb begin
    for (int c = 0; c < NUM_WB; c++) begin
      wb_id_a[c]   = rob.wb_id[c*DEPTH_LOG2 +: DEPTH_LOG2];
      wb_val_a[c]  = rob.wb_value[c*32 +: 32];
      wb_addr_a[c] = rob.wb_addr[c*32 +: 32];
      wb_ok[c]     = rob.wb_valid[c] && !rob.flush_out && in_flight(wb_id_a[c], head, count);
    end
  end

  // Operand bypass: later loop iterations override, so the highest wb channel wins.
  id_t         q_id    [2];
  logic        q_found [2];
  logic [31:0] q_val   [2];
  assign q_id[0]      = rob.q1_id;
  assign q_id[1]      = rob.q2_id;
  assign rob.q1_found = q_found[0];
  assign rob.q2_found = q_found[1];
  assign rob.q1_value = q_val[0];
  assign rob.q2_value = q_val[1];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      q_found[k] = e_done[q_id[k]];
      q_val[k]   = e_value[q_id[k]];
      if (do_alloc && rob.alloc_done && (q_id[k] == tail)) begin
        q_found[k] = 1'b1;
        q_val[k]   = rob.alloc_value;
      end
      for (int c = 0; c < NUM_WB; c++) begin
        if (rob.wb_valid[c] && (wb_id_a[c] == q_id[k])) begin
          q_found[k] = 1'b1;
          q_val[k]   = wb_val_a[c];
        end
      end
    end
  end

  logic [2:0]  h_type;
  logic        h_taken;
  logic [31:0] h_pc4;
  logic        head_ok;
  logic        st_free;
  logic        pop;
  assign h_type  = e_type[head];
  assign h_taken = e_value[head][0];
  assign h_pc4   = e_pc[head] + 32'd4;
  assign head_ok = (count != '0) && e_done[head] && !rob.halt_out && !rob.flush_out;
  assign st_free = !rob.st_valid || rob.st_ready;
  assign pop     = head_ok && ((h_type == T_STORE) ? st_free : (h_type != T_EXIT));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      e_done         <= '0;
      rob.rf_valid   <= 1'b0;
      rob.rf_rd      <= '0;
      rob.rf_value   <= '0;
      rob.rf_rob_id  <= '0;
      rob.st_valid   <= 1'b0;
      rob.st_addr    <= '0;
      rob.st_data    <= '0;
      rob.st_size    <= '0;
      rob.pred_valid <= 1'b0;
      rob.pred_pc    <= '0;
      rob.pred_taken <= 1'b0;
      rob.flush_out  <= 1'b0;
      rob.flush_pc   <= '0;
      rob.halt_out   <= 1'b0;
    end else if (rdy_in) begin
      rob.rf_valid   <= 1'b0;
      rob.pred_valid <= 1'b0;
      rob.flush_out  <= 1'b0;
      if (rob.st_valid && rob.st_ready) rob.st_valid <= 1'b0;
      // A store already handed to memory keeps its handshake across a flush.
      if (rob.flush_out) begin
        head   <= '0;
        tail   <= '0;
        count  <= '0;
        e_done <= '0;
      end else begin
        if (pop) begin
          head         <= head + id_t'(1);
          e_done[head] <= 1'b0;
          case (h_type)
            T_REG: begin
              rob.rf_valid  <= 1'b1;
              rob.rf_rd     <= e_rd[head];
              rob.rf_value  <= e_value[head];
              rob.rf_rob_id <= head;
            end
            T_JALR: begin
              rob.rf_valid  <= 1'b1;
              rob.rf_rd     <= e_rd[head];
              rob.rf_value  <= h_pc4;
              rob.rf_rob_id <= head;
              if (e_value[head] != e_tgt[head]) begin
                rob.flush_out <= 1'b1;
                rob.flush_pc  <= e_value[head];
              end
            end
            T_BRANCH: begin
              rob.pred_valid <= 1'b1;
              rob.pred_pc    <= e_pc[head];
              rob.pred_taken <= h_taken;
              if (h_taken != e_pred[head]) begin
                rob.flush_out <= 1'b1;
                rob.flush_pc  <= h_taken ? e_tgt[head] : h_pc4;
              end
            end
            T_STORE: begin
              rob.st_valid <= 1'b1;
              rob.st_addr  <= e_addr[head];
              rob.st_data  <= e_value[head];
              rob.st_size  <= e_size[head];
            end
            default: ;
          endcase
        end
        if (head_ok && (h_type == T_EXIT)) rob.halt_out <= 1'b1;
        if (do_alloc) begin
          e_type[tail]  <= rob.alloc_type;
          e_rd[tail]    <= rob.alloc_rd;
          e_pc[tail]    <= rob.alloc_pc;
          e_tgt[tail]   <= rob.alloc_tgt;
          e_pred[tail]  <= rob.alloc_pred;
          e_value[tail] <= rob.alloc_value;
          e_size[tail]  <= rob.alloc_st_size;
          e_done[tail]  <= rob.alloc_done;
          tail          <= tail + id_t'(1);
        end
        for (int c = 0; c < NUM_WB; c++) begin
          if (wb_ok[c]) begin
            e_done[wb_id_a[c]]  <= 1'b1;
            e_value[wb_id_a[c]] <= wb_val_a[c];
            e_addr[wb_id_a[c]]  <= wb_addr_a[c];
          end
        end
        count <= count + cnt_t'(do_alloc) - cnt_t'(pop);
      end
    end
  end
endmodule
